// File: rtl/pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
//   Shared types and constants for the test-pattern generator:
//   - mode_e   : pattern select values seen on the 'mode' port
//   - state_e  : write-sequencer FSM states
//   - SEC_*    : the eight 32-step hue sectors used by the rainbow pattern,
//                indexed by hue[7:5]
// -----------------------------------------------------------------------------
package pattern_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_RAINBOW = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_VGRAD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Hue sectors, named after what the colour is doing inside the sector.
  localparam logic [2:0] SEC_RED      = 3'd0; // (M,0,0)
  localparam logic [2:0] SEC_G_RISE   = 3'd1; // (M,f,0)
  localparam logic [2:0] SEC_YELLOW   = 3'd2; // (M,M,0)
  localparam logic [2:0] SEC_R_FALL   = 3'd3; // (M-f,M,0)
  localparam logic [2:0] SEC_GREEN    = 3'd4; // (0,M,0)
  localparam logic [2:0] SEC_G_FALL   = 3'd5; // (0,M-f,M)
  localparam logic [2:0] SEC_BLUE     = 3'd6; // (0,0,M)
  localparam logic [2:0] SEC_R_RISE   = 3'd7; // (f,0,M)

endpackage

// File: rtl/pattern_gen_if.sv
// -----------------------------------------------------------------------------
// pattern_gen_if
//   Pixel write channel between the pattern generator and display memory.
//   A write is accepted on a clock edge where write_en && wr_ready.
//   Signals:
//     write_en     generator -> memory  write request (valid)
//     write_x      generator -> memory  column, $clog2(WIDTH) bits
//     write_y      generator -> memory  row, $clog2(HEIGHT) bits
//     write_color  generator -> memory  {R,G,B}, 3*COLOR_BITS bits
//     wr_ready     memory -> generator  memory takes the presented write
//   Modports: master (generator side), slave (memory side).
// -----------------------------------------------------------------------------
interface pattern_gen_if #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int COLOR_BITS = 4
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic                    write_en;
  logic [XW-1:0]           write_x;
  logic [YW-1:0]           write_y;
  logic [3*COLOR_BITS-1:0] write_color;
  logic                    wr_ready;

  modport master (
    output write_en,
    output write_x,
    output write_y,
    output write_color,
    input  wr_ready
  );

  modport slave (
    input  write_en,
    input  write_x,
    input  write_y,
    input  write_color,
    output wr_ready
  );

endinterface

// File: rtl/pattern_gen_hue_to_rgb.sv
// -----------------------------------------------------------------------------
// hue_to_rgb
//   Combinational 8-bit hue to {R,G,B} conversion at full saturation/value.
//   hue[7:5] selects one of eight sectors; within a sector the ramp value f
//   is the top COLOR_BITS bits of hue[4:0].
//   Ports:
//     hue_i  in   8            hue, 0..255 around the colour wheel
//     rgb_o  out  3*COLOR_BITS {R,G,B}
// -----------------------------------------------------------------------------
module hue_to_rgb
  import pattern_pkg::*;
#(
  parameter int COLOR_BITS = 4
) (
  input  logic [7:0]              hue_i,
  output logic [3*COLOR_BITS-1:0] rgb_o
);

  localparam logic [COLOR_BITS-1:0] CMAX  = '1;
  localparam logic [COLOR_BITS-1:0] CZERO = '0;

  logic [COLOR_BITS-1:0] f;

  // COLOR_BITS never exceeds 5, so this keeps the top bits of the 5-bit ramp.
  assign f = COLOR_BITS'(hue_i[4:0] >> (5 - COLOR_BITS));

  always_comb begin
    rgb_o = {CZERO, CZERO, CZERO};
    case (hue_i[7:5])
      SEC_RED:    rgb_o = {CMAX,     CZERO,    CZERO};
      SEC_G_RISE: rgb_o = {CMAX,     f,        CZERO};
      SEC_YELLOW: rgb_o = {CMAX,     CMAX,     CZERO};
      SEC_R_FALL: rgb_o = {CMAX - f, CMAX,     CZERO};
      SEC_GREEN:  rgb_o = {CZERO,    CMAX,     CZERO};
      SEC_G_FALL: rgb_o = {CZERO,    CMAX - f, CMAX};
      SEC_BLUE:   rgb_o = {CZERO,    CZERO,    CMAX};
      SEC_R_RISE: rgb_o = {f,        CZERO,    CMAX};
      default:    rgb_o = {CZERO,    CZERO,    CZERO};
    endcase
  end

endmodule

// File: rtl/pattern_gen.sv
// -----------------------------------------------------------------------------
// pattern_gen
//   Raster test-pattern generator. On start it walks every pixel of a
//   WIDTH x HEIGHT frame in raster order and issues one write per pixel over
//   a valid/ready channel, with 'div' idle cycles between accepted writes.
//   Pattern inputs are latched at frame start so mid-frame changes only take
//   effect on the next frame.
//
//   Ports:
//     clk          in   1             clock, posedge
//     resetn       in   1             asynchronous active-low reset
//     start        in   1             begin a frame (ignored while busy)
//     continuous   in   1             restart automatically after each frame
//     mode         in   2             SOLID / RAINBOW / CHECKER / VGRAD
//     solid_color  in   3*COLOR_BITS  {R,G,B} for SOLID
//     border_en    in   1             white one-pixel frame border
//     div          in   DIV_W         idle cycles between accepted writes
//     busy         out  1             frame in progress
//     frame_done   out  1             pulse the cycle after the last accept
//     wr           pattern_gen_if.master  write_en/x/y/color, wr_ready
//
//   Optional build macro PATTERN_GEN_ANIM_EN: adds an 8-bit hue offset to the
//   rainbow that advances by one on every frame_done. Without it the rainbow
//   is static (offset fixed at zero, no register).
// -----------------------------------------------------------------------------
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int COLOR_BITS = 4,
  parameter int DIV_W      = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    continuous,
  input  logic [1:0]              mode,
  input  logic [3*COLOR_BITS-1:0] solid_color,
  input  logic                    border_en,
  input  logic [DIV_W-1:0]        div,
  output logic                    busy,
  output logic                    frame_done,
  pattern_gen_if.master           wr
);

  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);
  localparam int CW  = 3 * COLOR_BITS;
  localparam int XSH = 8 - XW;
  localparam int YSH = 8 - YW;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  state_e               state_q;
  logic [XW-1:0]        x_q;
  logic [YW-1:0]        y_q;
  logic [DIV_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 we_q;
  logic [XW-1:0]        wx_q;
  logic [YW-1:0]        wy_q;
  logic [CW-1:0]        wc_q;

  // Frame configuration, captured at frame start; pure data, no reset needed.
  mode_e                mode_q;
  logic [CW-1:0]        solid_q;
  logic                 border_q;
  logic [DIV_W-1:0]     div_q;

  logic                 accept;
  logic                 last_x;
  logic                 last_y;
  logic                 frame_end;
  logic                 cfg_load;
  logic [XW-1:0]        x_d;
  logic [YW-1:0]        y_d;
  logic [XW-1:0]        cx;
  logic [YW-1:0]        cy;
  logic [7:0]           hue_off;
  logic [7:0]           hue;
  logic [CW-1:0]        rainbow_rgb;
  logic [COLOR_BITS-1:0] vgrad_lvl;
  logic                 checker_on;
  logic                 on_border;
  logic [CW-1:0]        color_d;

  // In WRITE the registered coordinate always equals the one presented.
  assign accept    = (state_q == ST_WRITE) && wr.wr_ready;
  assign last_x    = (x_q == X_LAST);
  assign last_y    = (y_q == Y_LAST);
  assign frame_end = accept && last_x && last_y;
  assign cfg_load  = ((state_q == ST_IDLE) && start) || (frame_end && continuous);

  assign x_d = last_x ? '0 : x_q + 1'b1;
  assign y_d = last_x ? y_q + 1'b1 : y_q;

  // Colour is looked up for the pixel about to be loaded into the output
  // registers: the current one when leaving WAIT, the next one when a
  // back-to-back write (div = 0) follows an accept.
  assign cx = (state_q == ST_WRITE) ? x_d : x_q;
  assign cy = (state_q == ST_WRITE) ? y_d : y_q;

`ifdef PATTERN_GEN_ANIM_EN
  logic [7:0] hue_off_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hue_off_q <= 8'd0;
    end else if (frame_end) begin
      hue_off_q <= hue_off_q + 8'd1;
    end
  end

  assign hue_off = hue_off_q;
`else
  assign hue_off = 8'd0;
`endif

  assign hue = 8'(8'(cx) << XSH) + hue_off;

  hue_to_rgb #(
    .COLOR_BITS (COLOR_BITS)
  ) u_hue (
    .hue_i (hue),
    .rgb_o (rainbow_rgb)
  );

  assign vgrad_lvl  = COLOR_BITS'(8'(8'(cy) << YSH) >> (8 - COLOR_BITS));
  // y may be narrower than 4 bits, so test bit 3 on a zero-extended copy.
  assign checker_on = cx[3] ^ (|(8'(cy) & 8'h08));
  assign on_border  = border_q &&
                      ((cx == '0) || (cx == X_LAST) || (cy == '0) || (cy == Y_LAST));

  always_comb begin
    color_d = '0;
    case (mode_q)
      MODE_SOLID:   color_d = solid_q;
      MODE_RAINBOW: color_d = rainbow_rgb;
      MODE_CHECKER: color_d = {CW{checker_on}};
      MODE_VGRAD:   color_d = {vgrad_lvl, vgrad_lvl, vgrad_lvl};
      default:      color_d = '0;
    endcase
    if (on_border) begin
      color_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_load) begin
      mode_q   <= mode_e'(mode);
      solid_q  <= solid_color;
      border_q <= border_en;
      div_q    <= div;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      wx_q    <= '0;
      wy_q    <= '0;
      wc_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_WAIT;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= div;
            busy_q  <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_WRITE;
            we_q    <= 1'b1;
            wx_q    <= x_q;
            wy_q    <= y_q;
            wc_q    <= color_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_WRITE: begin
          if (wr.wr_ready) begin
            if (frame_end) begin
              done_q <= 1'b1;
              we_q   <= 1'b0;
              x_q    <= '0;
              y_q    <= '0;
              if (continuous) begin
                state_q <= ST_WAIT;
                cnt_q   <= div;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              x_q <= x_d;
              y_q <= y_d;
              if (div_q == '0) begin
                wx_q <= x_d;
                wy_q <= y_d;
                wc_q <= color_d;
              end else begin
                // Exit to WAIT is itself one idle cycle, hence div-1.
                we_q    <= 1'b0;
                state_q <= ST_WAIT;
                cnt_q   <= div_q - 1'b1;
              end
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign wr.write_en    = we_q;
  assign wr.write_x     = wx_q;
  assign wr.write_y     = wy_q;
  assign wr.write_color = wc_q;

endmodule

// File: tb/tb_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_pattern_gen
//   Self-checking bench for pattern_gen (64x64, 4 bits/channel, DIV_W=4).
//   A negedge monitor compares every accepted write against a raster-order
//   reference colour model and checks frame_done timing; directed sequences
//   cover reset, SOLID throughput, divider spacing, back-pressure hold,
//   randomized pattern frames with mid-frame input churn, and continuous mode.
// -----------------------------------------------------------------------------
module tb_pattern_gen;

  localparam int W    = 64;
  localparam int H    = 64;
  localparam int CB   = 4;
  localparam int DW   = 4;
  localparam int NPIX = W * H;

`ifdef PATTERN_GEN_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  logic          clk         = 1'b0;
  logic          resetn      = 1'b1;
  logic          start       = 1'b0;
  logic          continuous  = 1'b0;
  logic [1:0]    mode        = 2'd0;
  logic [11:0]   solid_color = 12'h000;
  logic          border_en   = 1'b0;
  logic [DW-1:0] div         = '0;
  logic          busy;
  logic          frame_done;

  pattern_gen_if #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB)) wr_if ();

  pattern_gen #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .COLOR_BITS (CB),
    .DIV_W      (DW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .continuous  (continuous),
    .mode        (mode),
    .solid_color (solid_color),
    .border_en   (border_en),
    .div         (div),
    .busy        (busy),
    .frame_done  (frame_done),
    .wr          (wr_if)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int unsigned cyc = 0;

  // Scoreboard state, shared by monitor and sequences.
  int          acc_idx = 0;
  int          fd_cnt  = 0;
  int          exp_off = 0;
  int unsigned first_acc_cyc = 0;
  int unsigned last_acc_cyc  = 0;
  int unsigned last_end_cyc  = 0;
  bit          gap_on  = 1'b0;
  int          gap_exp = 1;
  int          cfg_mode   = 0;
  logic [11:0] cfg_solid  = 12'h000;
  bit          cfg_border = 1'b0;
  bit          rdy_rand   = 1'b0;
  int          ex, ey;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference colour for pixel (x,y) straight from the pattern definitions.
  function automatic logic [11:0] exp_color(input int md, input logic [11:0] sc,
                                             input bit bd, input int x, input int y,
                                             input int off);
    int h, s, f, r, g, b, v;
    if (bd && (x == 0 || x == W - 1 || y == 0 || y == H - 1)) return 12'hFFF;
    case (md)
      0: return sc;
      1: begin
        h = (x * (256 / W) + off) % 256;
        s = h / 32;
        f = (h % 32) / 2;
        r = 0; g = 0; b = 0;
        case (s)
          0: begin r = 15;     g = 0;      b = 0;  end
          1: begin r = 15;     g = f;      b = 0;  end
          2: begin r = 15;     g = 15;     b = 0;  end
          3: begin r = 15 - f; g = 15;     b = 0;  end
          4: begin r = 0;      g = 15;     b = 0;  end
          5: begin r = 0;      g = 15 - f; b = 15; end
          6: begin r = 0;      g = 0;      b = 15; end
          default: begin r = f; g = 0;     b = 15; end
        endcase
        return 12'((r << 8) | (g << 4) | b);
      end
      2: return ((((x / 8) + (y / 8)) % 2) == 1) ? 12'hFFF : 12'h000;
      default: begin
        v = (y * (256 / H)) / 16;
        return 12'((v << 8) | (v << 4) | v);
      end
    endcase
  endfunction

  // Accept / frame_done monitor.
  always @(negedge clk) begin
    if (wr_if.write_en && wr_if.wr_ready) begin
      ex = acc_idx % W;
      ey = (acc_idx / W) % H;
      check("pixel", {2'b0, wr_if.write_x, 2'b0, wr_if.write_y, wr_if.write_color},
            {2'b0, 6'(ex), 2'b0, 6'(ey),
             exp_color(cfg_mode, cfg_solid, cfg_border, ex, ey, ANIM ? exp_off : 0)});
      if (acc_idx % NPIX == 0) first_acc_cyc = cyc;
      else if (gap_on) check("write_gap", cyc - last_acc_cyc, gap_exp);
      last_acc_cyc = cyc;
      acc_idx++;
      if (acc_idx % NPIX == 0) begin
        last_end_cyc = cyc;
        exp_off = (exp_off + 1) % 256;
        if (continuous) begin
          cfg_mode   = int'(mode);
          cfg_solid  = solid_color;
          cfg_border = border_en;
        end
      end
    end
    if (frame_done) begin
      fd_cnt++;
      check("done_timing", cyc, last_end_cyc + 1);
    end
  end

  // Random back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_rand) wr_if.wr_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input int md, input logic [11:0] sc, input bit bd,
                             input int dv, input bit ct);
    mode        = 2'(md);
    solid_color = sc;
    border_en   = bd;
    div         = DW'(dv);
    continuous  = ct;
    cfg_mode    = md;
    cfg_solid   = sc;
    cfg_border  = bd;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic clear_sb();
    acc_idx = 0;
    fd_cnt  = 0;
  endtask

  // Run until 'target' frames are done; optionally churn inputs meanwhile.
  task automatic run_until(input int target, input int limit, input bit perturb,
                           input bit stop_cont);
    int n = 0;
    int drops = 0;
    while (fd_cnt < target && n < limit) begin
      tick();
      n++;
      if (perturb) begin
        mode        = 2'($urandom_range(0, 3));
        solid_color = 12'($urandom_range(0, 4095));
        border_en   = 1'($urandom_range(0, 1));
        div         = DW'($urandom_range(0, 1));
        start       = (acc_idx < target * NPIX) ? ($urandom_range(0, 7) == 0) : 1'b0;
      end
      if (stop_cont && acc_idx >= NPIX) continuous = 1'b0;
      if (acc_idx < target * NPIX && !busy) drops++;
    end
    start = 1'b0;
    check("frames_done", fd_cnt, target);
    check("busy_hold", drops, 0);
  endtask

  initial begin
    int n;
    wr_if.wr_ready = 1'b0;

    // Reset
    #1 resetn = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {wr_if.write_en, wr_if.write_x, wr_if.write_y,
                          wr_if.write_color, busy, frame_done}, 0);
    resetn = 1'b1;
    repeat (3) tick();
    check("idle_busy", busy, 0);

    // SOLID, div=0, always ready: 4096 back-to-back writes
    clear_sb();
    gap_on = 1'b1; gap_exp = 1;
    rdy_rand = 1'b0; wr_if.wr_ready = 1'b1;
    start_frame(0, 12'hA5C, 1'b0, 0, 1'b0);
    run_until(1, 6000, 1'b0, 1'b0);
    check("solid_accepts", acc_idx, NPIX);
    check("solid_span", last_acc_cyc - first_acc_cyc, NPIX - 1);
    repeat (5) tick();
    check("solid_idle", {busy, wr_if.write_en}, 0);
    check("solid_one_done", fd_cnt, 1);

    // div=3 spacing, then reset mid-frame
    clear_sb();
    gap_exp = 4;
    start_frame(2, 12'h000, 1'($urandom_range(0, 1)), 3, 1'b0);
    n = 0;
    while (acc_idx < 150 && n < 2000) begin tick(); n++; end
    check("div3_progress", acc_idx >= 150, 1);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("rst_midframe", {wr_if.write_en, wr_if.write_x, wr_if.write_y,
                           wr_if.write_color, busy, frame_done}, 0);
    clear_sb();
    exp_off = 0;
    tick(); tick();
    resetn = 1'b1;
    repeat (20) tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_we", wr_if.write_en, 0);
    check("post_rst_no_done", fd_cnt, 0);
    gap_on = 1'b0;

    // Back-pressure hold on (3,0), RAINBOW with border
    clear_sb();
    wr_if.wr_ready = 1'b0;
    start_frame(1, 12'h000, 1'b1, 0, 1'b0);
    n = 0;
    while (!wr_if.write_en && n < 10) begin tick(); n++; end
    check("first_present", {wr_if.write_en, wr_if.write_x, wr_if.write_y}, {1'b1, 6'd0, 6'd0});
    wr_if.wr_ready = 1'b1;
    repeat (3) tick();
    wr_if.wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {wr_if.write_en, wr_if.write_x, wr_if.write_y, wr_if.write_color},
            {1'b1, 6'd3, 6'd0, exp_color(1, 12'h000, 1'b1, 3, 0, ANIM ? exp_off : 0)});
      @(posedge clk);
      #2;
    end
    wr_if.wr_ready = 1'b1;
    tick();
    check("after_accept", {wr_if.write_en, wr_if.write_x, wr_if.write_y}, {1'b1, 6'd4, 6'd0});
    rdy_rand = 1'b1;
    run_until(1, 30000, 1'b0, 1'b0);

    // Randomized frames with mid-frame input churn (must be ignored)
    clear_sb();
    start_frame(1, 12'h000, 1'b0, 1, 1'b0);
    run_until(1, 30000, 1'b1, 1'b0);
    tick();
    check("rand_idle", busy, 0);
    start_frame(int'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b0);
    run_until(2, 30000, 1'b1, 1'b0);
    tick();
    check("rand_idle2", busy, 0);

    // Continuous: two frames back to back, busy never drops
    clear_sb();
    start_frame(3, 12'h000, 1'b0, 0, 1'b1);
    run_until(2, 60000, 1'b1, 1'b1);
    repeat (3) tick();
    check("cont_end_busy", busy, 0);
    check("cont_accepts", acc_idx, 2 * NPIX);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
